hs_sync_fifo: RTL
=================

HS_SYNC_FIFO -- requirements
Module: hs_sync_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, number of 16-bit entries; SHALL be a power of two and at least 2.
REQ-002 Parameter: AW, default 2, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: valid_up  input  1  upstream word offered.
REQ-006 Port: data_up  input  16  upstream word.
REQ-007 Port: ready_up  output  1  FIFO accepts a word this cycle.
REQ-008 Port: valid_down  output  1  head word available.
REQ-009 Port: data_down  output  16  head word.
REQ-010 Port: ready_down  input  1  downstream accepts the head word.
REQ-011 Port: count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-012 Port: almost_full  output  1  high when count >= DEPTH-1.

Function
REQ-013 push = valid_up & ready_up; pop = valid_down & ready_down; both SHALL be evaluated in the same cycle.
REQ-014 ready_up SHALL equal (count != DEPTH) and SHALL depend only on registered state, never combinationally on ready_down or valid_up.
REQ-015 valid_down SHALL equal (count != 0) and SHALL depend only on registered state, never combinationally on valid_up.
REQ-016 data_down SHALL equal the storage entry at the read pointer when count != 0, and SHALL be 16'h0000 when count == 0.
REQ-017 On push, data_up SHALL be written at the write pointer, and the write pointer SHALL advance by 1 modulo DEPTH.
REQ-018 On pop, the read pointer SHALL advance by 1 modulo DEPTH.
REQ-019 Count update SHALL be:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
REQ-020 Latency: a word pushed at edge N SHALL appear on valid_down/data_down after edge N; there is no same-cycle bypass when empty.
REQ-021 Ordering SHALL be strict FIFO; no word SHALL be dropped or duplicated.
REQ-022 Full (count == DEPTH): ready_up=0, so no push occurs even if pop is asserted in the same cycle; ready_up SHALL rise in the cycle after that pop.
REQ-023 Empty (count == 0): valid_down=0, so no pop occurs; ready_down has no effect.
REQ-024 Simultaneous push and pop at count 1..DEPTH-1: count SHALL be unchanged and both pointers SHALL advance.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no bubble or stall.
REQ-026 almost_full SHALL be derived combinationally from registered count.
REQ-027 Storage contents SHALL need no reset; the visible data_down SHALL still be 0 whenever the FIFO is empty.
REQ-028 Throughput SHALL be one word per cycle sustained when neither full nor empty.

Reset
REQ-029 While rst=0, the following SHALL hold asynchronously, regardless of clk:
  - write and read pointers = 0
  - count = 0
  - valid_down = 0, data_down = 0
  - ready_up = 1, almost_full = 0
REQ-030 Reset asserted mid-operation SHALL discard all stored words immediately.
REQ-031 After rst deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-032 Reset check:
  - Stimulus: push 3 words, then pulse rst low between clock edges.
  - Required: count=0, valid_down=0, data_down=0 and ready_up=1 immediately.
  - Then: the next push of 16'h00AA appears at data_down one cycle later.
REQ-033 Fill and drain:
  - Stimulus: ready_down=0; push 16'h0001..16'h0004 (DEPTH=4).
  - Required: ready_up=0, count=4, almost_full=1 from count=3.
  - Then: assert ready_down; outputs are 1,2,3,4 in order on consecutive cycles; count returns to 0 and valid_down=0.
REQ-034 Full with pop:
  - Stimulus: at count=4, valid_up=1 with 16'h0005 and ready_down=1 in the same cycle.
  - Required: 16'h0001 popped, 16'h0005 not accepted, count=3.
  - Then: 16'h0005 is accepted the next cycle.
REQ-035 Streaming across wrap:
  - Stimulus: valid_up=1 and ready_down=1 continuously for 10 cycles after one preloaded word.
  - Required: count stays 1; outputs are an in-order incrementing sequence across pointer wrap with no gaps.
REQ-036 Empty behaviour:
  - Stimulus: count=0, ready_down=1, valid_up=1 with 16'h1234.
  - Required: valid_down=0 in that cycle; valid_down=1 with data_down=16'h1234 the next cycle.
REQ-037 Random check:
  - Stimulus: random valid_up/ready_down at 50% each for 2000 cycles.
  - Required: a scoreboard matches every popped word in order, count stays within 0..DEPTH, and there are no X values on outputs.

Source files
------------

// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: single-clock 16-bit FIFO with valid/ready handshakes on both
// sides. Flow-control outputs are decoded from registered occupancy only, so
// neither handshake has a combinational path from the opposite side.
module hs_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_up,
    input  logic [15:0]   data_up,
    output logic          ready_up,
    output logic          valid_down,
    output logic [15:0]   data_down,
    input  logic          ready_down,
    output logic [AW:0]   count,
    output logic          almost_full
);

    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ALMOST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ZERO   = '0;
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    // Handshake decode; everything visible comes from count_q, which is
    // cleared asynchronously, so the reset values appear without a clock.
    always_comb begin
        ready_up    = (count_q != CNT_FULL);
        valid_down  = (count_q != CNT_ZERO);
        almost_full = (count_q >= CNT_ALMOST);
        push        = valid_up & ready_up;
        pop         = valid_down & ready_down;
        count       = count_q;
        data_down   = valid_down ? mem[rd_ptr] : 16'h0000;
    end

    // Storage array carries no reset; an empty FIFO masks it at data_down.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_up;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is 2**AW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

endmodule
